// File: rtl/perceptron_trainer.sv
// perceptron_trainer: online fixed-step perceptron trainer, one sample per 4 clocks,
// weights driven straight into the inference perceptron.
module perceptron_trainer #(
  parameter int N          = 8,
  parameter int THRESH     = 320,
  parameter int LR_SHIFT   = 2,
  parameter int B_STEP     = 16,
  parameter int W_INIT     = 1,
  parameter int CONV_COUNT = 4
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [N-1:0]   x1,
  input  logic [N-1:0]   x2,
  input  logic           target,
  input  logic           s_valid,
  output logic           s_ready,
  output logic [N-1:0]   w1,
  output logic [N-1:0]   w2,
  output logic [2*N-1:0] b,
  output logic           pred,
  output logic           err,
  output logic           done_valid,
  output logic           converged,
  output logic [15:0]    err_count
);
  localparam int CW = $clog2(CONV_COUNT + 1);
  typedef enum logic [1:0] {IDLE, MUL, SUM, UPD} state_t;
  state_t state, state_nx;
  logic [N-1:0] xa, xb, d1, d2, w1_inc, w2_inc, w1_dec, w2_dec;
  logic [N:0] w1_add, w2_add;
  logic [2*N:0] b_add;
  logic [2*N-1:0] p1, p2, b_inc, b_dec;
  logic [2*N+1:0] sum;
  logic [CW-1:0] cnt;
  logic tgt, pred_i, miss;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = s_valid ? MUL : IDLE;
      MUL:     state_nx = SUM;
      SUM:     state_nx = UPD;
      default: state_nx = IDLE;
    endcase
  end
  assign s_ready   = state == IDLE;
  assign converged = cnt == CW'(CONV_COUNT);
  assign pred_i    = sum >= (2*N+2)'(THRESH);
  assign miss      = pred_i != tgt;
  // saturating step arithmetic; one extra bit catches overflow on the way up
  assign d1     = xa >> LR_SHIFT;
  assign d2     = xb >> LR_SHIFT;
  assign w1_add = {1'b0, w1} + {1'b0, d1};
  assign w2_add = {1'b0, w2} + {1'b0, d2};
  assign w1_inc = w1_add[N] ? '1 : w1_add[N-1:0];
  assign w2_inc = w2_add[N] ? '1 : w2_add[N-1:0];
  assign w1_dec = w1 > d1 ? w1 - d1 : '0;
  assign w2_dec = w2 > d2 ? w2 - d2 : '0;
  assign b_add  = {1'b0, b} + (2*N+1)'(B_STEP);
  assign b_inc  = b_add[2*N] ? '1 : b_add[2*N-1:0];
  assign b_dec  = b > (2*N)'(B_STEP) ? b - (2*N)'(B_STEP) : '0;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      xa         <= '0;
      xb         <= '0;
      tgt        <= 1'b0;
      p1         <= '0;
      p2         <= '0;
      sum        <= '0;
      w1         <= N'(W_INIT);
      w2         <= N'(W_INIT);
      b          <= '0;
      pred       <= 1'b0;
      err        <= 1'b0;
      done_valid <= 1'b0;
      err_count  <= '0;
      cnt        <= '0;
    end else begin
      done_valid <= state == UPD;
      err        <= state == UPD && miss;
      if (s_valid && s_ready) begin
        xa  <= x1;
        xb  <= x2;
        tgt <= target;
      end
      if (state == MUL) begin
        p1 <= (2*N)'(xa) * (2*N)'(w1);
        p2 <= (2*N)'(xb) * (2*N)'(w2);
      end
      if (state == SUM) sum <= (2*N+2)'(p1) + (2*N+2)'(p2) + (2*N+2)'(b);
      if (state == UPD) begin
        pred <= pred_i;
        if (miss) begin
          w1        <= tgt ? w1_inc : w1_dec;
          w2        <= tgt ? w2_inc : w2_dec;
          b         <= tgt ? b_inc : b_dec;
          err_count <= err_count == '1 ? err_count : err_count + 16'd1;
          cnt       <= '0;
        end else begin
          cnt <= converged ? cnt : cnt + CW'(1);
        end
      end
    end
endmodule
